level_sequencer: RTL and testbench

- Parametrised, multi-level game controller for the maze game, sitting between the player buttons, the maze storage and the win/lose detectors.
- Clears the maze one row per cycle, then loads letter placements from an external per-level placement ROM one letter per cycle.
- Runs a per-level countdown timer and sequences through NUM_LEVELS levels.
- Replaces the full-array combinational broadcast used previously with a narrow row-clear and letter-write interface.

---
 rtl/level_sequencer_if.sv | 39 +++
 rtl/level_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_level_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/level_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : level_sequencer_if
//  Purpose  : Narrow maze-storage and placement-ROM bus of the level
//             sequencer (row clear, single-cell letter write, ROM lookup).
//  Revision : 1.0  initial release
// ============================================================================
interface level_sequencer_if #(
   parameter int SIZE_Y      = 20,
   parameter int SIZE_X      = 40,
   parameter int NUM_LETTERS = 26,
   parameter int NUM_LEVELS  = 4
);
   localparam int YW = $clog2(SIZE_Y);
   localparam int XW = $clog2(SIZE_X);
   localparam int AW = $clog2(NUM_LEVELS*NUM_LETTERS);

   logic [AW-1:0] rom_addr;
   logic [YW-1:0] letter_y;
   logic [XW-1:0] letter_x;
   logic          clr;
   logic [YW-1:0] clr_row;
   logic          wr_en;
   logic [YW-1:0] wr_y;
   logic [XW-1:0] wr_x;

   // Sequencer side: drives ROM address and maze strobes, receives ROM data
   modport master (
      output rom_addr, clr, clr_row, wr_en, wr_y, wr_x,
      input  letter_y, letter_x
   );

   // ROM / maze side
   modport slave (
      input  rom_addr, clr, clr_row, wr_en, wr_y, wr_x,
      output letter_y, letter_x
   );
endinterface
`default_nettype wire

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : level_sequencer
//  Purpose  : Multi-level maze game controller. Clears the maze a row per
//             cycle, loads letter placements from a per-level ROM, runs the
//             per-level countdown and steps through NUM_LEVELS levels.
//  Revision : 1.0  initial release
// ============================================================================
module level_sequencer #(
   parameter int          SIZE_Y      = 20,
   parameter int          SIZE_X      = 40,
   parameter int          NUM_LETTERS = 26,
   parameter int          NUM_LEVELS  = 4,
   parameter int          TIME_LIMIT  = 99,
   parameter logic [7:0]  ILC_INIT    = 8'h63
) (
   input  wire logic                              Clk,
   input  wire logic                              Reset,
   input  wire logic                              Start,
   input  wire logic                              win,
   input  wire logic                              lose,
   input  wire logic                              tick,
   level_sequencer_if.master                      bus,
   output logic                                   init,
   output logic                                   ready,
   output logic                                   start,
   output logic [7:0]                             ilc,
   output logic [$clog2(NUM_LEVELS)-1:0]          level,
   output logic [$clog2(TIME_LIMIT+1)-1:0]        time_left,
   output logic                                   game_done,
   output logic                                   cfg_err
);
   localparam int YW   = $clog2(SIZE_Y);
   localparam int XW   = $clog2(SIZE_X);
   localparam int AW   = $clog2(NUM_LEVELS*NUM_LETTERS);
   localparam int LVW  = $clog2(NUM_LEVELS);
   localparam int TW   = $clog2(TIME_LIMIT+1);
   localparam int CMAX = (SIZE_Y > NUM_LETTERS+1) ? SIZE_Y : NUM_LETTERS+1;
   localparam int CW   = $clog2(CMAX+1);

   localparam logic [YW-1:0]  c_Y_MAX     = YW'(SIZE_Y-1);
   localparam logic [XW-1:0]  c_X_MAX     = XW'(SIZE_X-1);
   localparam logic [AW-1:0]  c_NL        = AW'(NUM_LETTERS);
   localparam logic [CW-1:0]  c_CLR_LAST  = CW'(SIZE_Y-1);
   localparam logic [CW-1:0]  c_LOAD_LAST = CW'(NUM_LETTERS);
   localparam logic [LVW-1:0] c_LVL_LAST  = LVW'(NUM_LEVELS-1);
   localparam logic [TW-1:0]  c_TL        = TW'(TIME_LIMIT);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_READY = 3'd3,
      S_WIN   = 3'd4,
      S_LOSE  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t          r_state,   w_state_nxt;
   logic            r_start_q;
   logic [LVW-1:0]  r_level,   w_level_nxt;
   logic [TW-1:0]   r_time,    w_time_nxt;
   logic [CW-1:0]   r_cnt,     w_cnt_nxt;
   logic            r_cfg_err, w_cfg_err_nxt;
   logic            w_rel;
   logic            w_bad;

   // Button acts on release only: it was pressed (low) last cycle, high now
   assign w_rel = Start & ~r_start_q;
   // ROM coordinate outside the maze
   assign w_bad = (bus.letter_y > c_Y_MAX) || (bus.letter_x > c_X_MAX);

   assign level     = r_level;
   assign time_left = r_time;
   assign cfg_err   = r_cfg_err;

   // State and datapath registers; button sampler idles released
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_START;
         r_start_q <= 1'b1;
         r_level   <= '0;
         r_time    <= '0;
         r_cnt     <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_start_q <= Start;
         r_level   <= w_level_nxt;
         r_time    <= w_time_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cfg_err <= w_cfg_err_nxt;
      end
   end

   // Next-state, counters and per-state strobes
   always_comb begin
      w_state_nxt   = r_state;
      w_level_nxt   = r_level;
      w_time_nxt    = r_time;
      w_cnt_nxt     = r_cnt;
      w_cfg_err_nxt = r_cfg_err;
      bus.rom_addr  = '0;
      bus.clr       = 1'b0;
      bus.clr_row   = '0;
      bus.wr_en     = 1'b0;
      bus.wr_y      = bus.letter_y;
      bus.wr_x      = bus.letter_x;
      init          = 1'b0;
      ready         = 1'b0;
      start         = 1'b0;
      ilc           = 8'h00;
      game_done     = 1'b0;

      case (r_state)
         S_START: begin
            start = ~r_start_q;
            if (w_rel) begin
               w_level_nxt = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            bus.clr     = 1'b1;
            bus.clr_row = YW'(r_cnt);
            init        = (r_cnt == '0);
            ilc         = ILC_INIT;
            if (r_cnt == c_CLR_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_LOAD;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_LOAD: begin
            ilc = ILC_INIT;
            // ROM data lags the address by one cycle, so writes run one behind
            if (r_cnt < c_LOAD_LAST) begin
               bus.rom_addr = AW'(r_level) * c_NL + AW'(r_cnt);
            end
            if (r_cnt != '0) begin
               if (w_bad) begin
                  w_cfg_err_nxt = 1'b1;
               end else begin
                  bus.wr_en = 1'b1;
               end
            end
            if (r_cnt == c_LOAD_LAST) begin
               w_cnt_nxt   = '0;
               w_time_nxt  = c_TL;
               w_state_nxt = S_READY;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_READY: begin
            ready = 1'b1;
            if (win) begin
               w_state_nxt = S_WIN;
            end else if (lose) begin
               w_state_nxt = S_LOSE;
            end else if (tick) begin
               if (r_time <= TW'(1)) begin
                  w_time_nxt  = '0;
                  w_state_nxt = S_LOSE;
               end else begin
                  w_time_nxt = r_time - TW'(1);
               end
            end
         end
         S_WIN: begin
            if (w_rel) begin
               if (r_level != c_LVL_LAST) begin
                  w_level_nxt = r_level + LVW'(1);
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_CLEAR;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_LOSE, S_DONE: begin
            game_done = (r_state == S_DONE);
            if (w_rel) begin
               w_level_nxt = '0;
               w_time_nxt  = '0;
               w_state_nxt = S_START;
            end
         end
         default: begin
            w_state_nxt = S_START;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_level_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_level_sequencer
//  Purpose  : Directed self-checking bench for level_sequencer with a
//             registered placement ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_level_sequencer;
   localparam int SY  = 20;
   localparam int SX  = 40;
   localparam int NL  = 26;
   localparam int NLV = 4;
   localparam int TL  = 3;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       Start = 1'b1;
   logic       win   = 1'b0;
   logic       lose  = 1'b0;
   logic       tick  = 1'b0;
   logic       init, ready, start, game_done, cfg_err;
   logic [7:0] ilc;
   logic [1:0] level;
   logic [1:0] time_left;

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0] rom_y [0:NLV*NL-1];
   logic [5:0] rom_x [0:NLV*NL-1];

   always #5 clk = ~clk;

   level_sequencer_if #(.SIZE_Y(SY), .SIZE_X(SX), .NUM_LETTERS(NL), .NUM_LEVELS(NLV)) u_if ();

   level_sequencer #(
      .SIZE_Y(SY), .SIZE_X(SX), .NUM_LETTERS(NL), .NUM_LEVELS(NLV),
      .TIME_LIMIT(TL), .ILC_INIT(8'h63)
   ) u_dut (
      .Clk(clk), .Reset(rst), .Start(Start), .win(win), .lose(lose), .tick(tick),
      .bus(u_if.master),
      .init(init), .ready(ready), .start(start), .ilc(ilc), .level(level),
      .time_left(time_left), .game_done(game_done), .cfg_err(cfg_err)
   );

   // Placement ROM: one cycle read latency
   always @(posedge clk) begin
      u_if.letter_y <= rom_y[u_if.rom_addr];
      u_if.letter_x <= rom_x[u_if.rom_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_release();
      Start = 1'b0;
      step();
      Start = 1'b1;
      step();
   endtask

   // Called in the first CLEAR cycle; returns in the first GAME_READY cycle
   task automatic clear_load(input int lvl);
      for (int i = 0; i < SY; i++) begin
         check("clr", u_if.clr, 1);
         check("clr_row", u_if.clr_row, i);
         check("init", init, (i == 0) ? 1 : 0);
         check("ilc_clear", ilc, 8'h63);
         step();
      end
      for (int k = 0; k <= NL; k++) begin
         int  idx;
         logic exp_wr;
         idx    = lvl*NL + k - 1;
         exp_wr = (k >= 1) && (rom_y[idx] < SY) && (rom_x[idx] < SX);
         if (k < NL) check("rom_addr", u_if.rom_addr, lvl*NL + k);
         check("wr_en", u_if.wr_en, exp_wr);
         if (exp_wr) begin
            check("wr_y", u_if.wr_y, rom_y[idx]);
            check("wr_x", u_if.wr_x, rom_x[idx]);
         end
         check("ilc_load", ilc, 8'h63);
         step();
      end
      check("ready", ready, 1);
      check("time_full", time_left, TL);
      check("level_ready", level, lvl);
   endtask

   initial begin
      for (int a = 0; a < NLV*NL; a++) begin
         rom_y[a] = 5'((a*3 + 1) % SY);
         rom_x[a] = 6'((a*7 + 2) % SX);
      end
      rom_y[0] = 5'd2;  rom_x[0] = 6'd7;
      rom_y[1] = 5'd7;  rom_x[1] = 6'd1;
      rom_y[2] = 5'd3;  rom_x[2] = 6'd22;
      rom_y[5] = 5'd20; rom_x[5] = 6'd3;

      // Reset state
      repeat (2) step();
      check("rst_level", level, 0);
      check("rst_time", time_left, 0);
      check("rst_ready", ready, 0);
      check("rst_start", start, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_clr", u_if.clr, 0);
      check("rst_wr_en", u_if.wr_en, 0);
      check("rst_ilc", ilc, 0);
      rst = 1'b0;
      step();

      // Start screen: press shows indicator, release enters CLEAR
      Start = 1'b0;
      step();
      check("start_held", start, 1);
      check("no_clear_on_press", u_if.clr, 0);
      Start = 1'b1;
      step();
      check("start_released", start, 0);
      clear_load(0);
      check("cfg_err_set", cfg_err, 1);

      // Timeout: 3,2,1,0 then LOSE
      for (int t = TL - 1; t >= 0; t--) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("time_dec", time_left, t);
      end
      check("lose_ready", ready, 0);
      check("lose_done", game_done, 0);
      press_release();
      check("lose_level", level, 0);
      check("lose_time", time_left, 0);
      check("lose_clr", u_if.clr, 0);

      // Restart; win coincident with tick at time_left 1
      press_release();
      clear_load(0);
      check("cfg_err_sticky", cfg_err, 1);
      repeat (2) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
      end
      check("time_one", time_left, 1);
      win = 1'b1; tick = 1'b1;
      step();
      win = 1'b0; tick = 1'b0;
      check("win_ready", ready, 0);
      check("win_time_hold", time_left, 1);
      // Button held low in WIN does nothing until released
      Start = 1'b0;
      repeat (3) step();
      check("held_level", level, 0);
      check("held_clr", u_if.clr, 0);
      Start = 1'b1;
      step();
      check("lvl1_level", level, 1);
      clear_load(1);

      // win beats lose
      win = 1'b1; lose = 1'b1;
      step();
      win = 1'b0; lose = 1'b0;
      press_release();
      check("prio_level", level, 2);
      check("prio_clr", u_if.clr, 1);
      clear_load(2);
      win = 1'b1; step(); win = 1'b0;
      press_release();
      clear_load(3);
      win = 1'b1; step(); win = 1'b0;
      check("win_last_done", game_done, 0);
      press_release();
      check("done", game_done, 1);
      check("done_level", level, 3);
      check("done_clr", u_if.clr, 0);
      press_release();
      check("done_exit", game_done, 0);
      check("done_exit_level", level, 0);
      check("done_exit_time", time_left, 0);

      // Reset in the middle of the level-2 load
      press_release();
      repeat (SY + NL + 1) step();
      win = 1'b1; step(); win = 1'b0;
      press_release();
      repeat (SY + NL + 1) step();
      win = 1'b1; step(); win = 1'b0;
      press_release();
      check("lvl2_again", level, 2);
      repeat (SY + 10) step();
      check("midload_wr", u_if.wr_en, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_wr_en", u_if.wr_en, 0);
      check("arst_level", level, 0);
      check("arst_clr", u_if.clr, 0);
      check("arst_ilc", ilc, 0);
      check("arst_cfg_err", cfg_err, 0);
      check("arst_time", time_left, 0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_clr", u_if.clr, 0);
      check("post_rst_ready", ready, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
